// File: rtl/cpu_debug_slave_sysclk_q.sv
// System-clock side of the debug slave: synchronises JTAG update strobes, queues {IR, DR} commands
// and emits one-cycle per-channel action pulses. Optional push counter: DEBUG_SLAVE_CMD_COUNT_EN.
module cpu_debug_slave_sysclk_q #(
  parameter int IR_W       = 2,
  parameter int DR_W       = 38,
  parameter int SYNC_DEPTH = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ACT_BIT    = 35
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [IR_W-1:0]               ir_in,
  input  logic [DR_W-1:0]               sr,
  input  logic                          vs_uir,
  input  logic                          vs_udr,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DR_W-1:0]               jdo,
  output logic [IR_W-1:0]               jir,
  output logic [(2**IR_W)-1:0]          take_action,
  output logic [(2**IR_W)-1:0]          take_no_action,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic [15:0]                   cmd_count
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int NCH     = 2**IR_W;
  localparam int ENT_W   = IR_W + DR_W;
  localparam int ARM_CYC = SYNC_DEPTH + 1;
  localparam int ARM_W   = $clog2(ARM_CYC + 1);

  logic [SYNC_DEPTH-1:0] r_uir_sync;
  logic [SYNC_DEPTH-1:0] r_udr_sync;
  logic                  r_uir_prev;
  logic                  r_udr_prev;
  logic [ARM_W-1:0]      r_arm_cnt;
  logic [IR_W-1:0]       r_ir_q;

  logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
  logic [CW-1:0]         r_wr_cnt;
  logic [CW-1:0]         r_rd_cnt;
  logic                  r_overflow;
  logic [DR_W-1:0]       r_jdo;
  logic [IR_W-1:0]       r_jir;
  logic [NCH-1:0]        r_take_action;
  logic [NCH-1:0]        r_take_no_action;

  logic                  w_uir_s;
  logic                  w_udr_s;
  logic                  w_armed;
  logic                  w_uir_rise;
  logic                  w_udr_rise;
  logic [CW-1:0]         w_level;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_drop;
  logic [ENT_W-1:0]      w_head;
  logic [IR_W-1:0]       w_head_ir;
  logic [DR_W-1:0]       w_head_dr;
  logic [NCH-1:0]        w_onehot;

  // Strobe synchronisers and edge-detect history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_uir_sync <= '0;
      r_udr_sync <= '0;
      r_uir_prev <= 1'b0;
      r_udr_prev <= 1'b0;
      r_arm_cnt  <= '0;
    end else begin
      r_uir_sync <= {r_uir_sync[SYNC_DEPTH-2:0], vs_uir};
      r_udr_sync <= {r_udr_sync[SYNC_DEPTH-2:0], vs_udr};
      r_uir_prev <= w_uir_s;
      r_udr_prev <= w_udr_s;
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      end
    end
  end

  // Edges stay masked until the history register has seen the synchronised level,
  // so a strobe already high when reset releases never looks like a fresh edge.
  assign w_uir_s    = r_uir_sync[SYNC_DEPTH-1];
  assign w_udr_s    = r_udr_sync[SYNC_DEPTH-1];
  assign w_armed    = (r_arm_cnt == ARM_W'(ARM_CYC));
  assign w_uir_rise = w_armed && w_uir_s && !r_uir_prev;
  assign w_udr_rise = w_armed && w_udr_s && !r_udr_prev;

  // A coincident udr edge pushes the old IR because the push reads r_ir_q before it updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir_q <= '0;
    end else if (w_uir_rise) begin
      r_ir_q <= ir_in;
    end
  end

  // Handshake: the head entry transfers on any clock edge where cmd_valid and cmd_ready
  // are both high; cmd_valid never depends on cmd_ready and an empty queue ignores cmd_ready.
  assign w_level   = r_wr_cnt - r_rd_cnt;
  assign w_empty   = (w_level == '0);
  assign w_full    = (w_level == CW'(FIFO_DEPTH));
  assign w_pop     = !w_empty && cmd_ready;
  assign w_push_ok = w_udr_rise && (!w_full || w_pop);
  assign w_drop    = w_udr_rise && w_full && !w_pop;

  assign w_head    = r_mem[r_rd_cnt[AW-1:0]];
  assign w_head_ir = w_head[ENT_W-1 -: IR_W];
  assign w_head_dr = w_head[DR_W-1:0];

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NCH; i++) begin
      w_onehot[i] = (w_head_ir == IR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_cnt[AW-1:0]] <= {r_ir_q, sr};
        r_wr_cnt                <= r_wr_cnt + CW'(1);
      end
      if (w_pop) begin
        r_rd_cnt <= r_rd_cnt + CW'(1);
      end
    end
  end

  // Set wins over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // Popped entry is held on jdo/jir; the channel pulse lasts exactly the cycle after the pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jdo            <= '0;
      r_jir            <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
    end else begin
      r_take_action    <= '0;
      r_take_no_action <= '0;
      if (w_pop) begin
        r_jdo <= w_head_dr;
        r_jir <= w_head_ir;
        if (w_head_dr[ACT_BIT]) begin
          r_take_action <= w_onehot;
        end else begin
          r_take_no_action <= w_onehot;
        end
      end
    end
  end

`ifdef DEBUG_SLAVE_CMD_COUNT_EN
  logic [15:0] r_cmd_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_count <= 16'h0000;
    end else if (w_push_ok && (r_cmd_count != 16'hFFFF)) begin
      r_cmd_count <= r_cmd_count + 16'd1;
    end
  end

  assign cmd_count = r_cmd_count;
`else
  assign cmd_count = 16'h0000;
`endif

  assign cmd_valid      = !w_empty;
  assign fifo_level     = w_level;
  assign jdo            = r_jdo;
  assign jir            = r_jir;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_cpu_debug_slave_sysclk_q.sv
// Bench for cpu_debug_slave_sysclk_q: directed strobes, expected pulses queued at issue time
// and matched by a negedge monitor.
module tb_cpu_debug_slave_sysclk_q;

  logic        clk;
  logic        reset_n;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_uir;
  logic        vs_udr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  fifo_level;
  logic [37:0] jdo;
  logic [1:0]  jir;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        overflow;
  logic        ovf_clr;
  logic [15:0] cmd_count;

  // Entry layout: {jir[1:0], jdo[37:0], take_action[3:0], take_no_action[3:0]}
  localparam int W = 48;
  logic [W-1:0] exp_q[$];

  int n_tests;
  int n_fail;
  int exp_cnt;

  cpu_debug_slave_sysclk_q dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ir_in          (ir_in),
    .sr             (sr),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .fifo_level     (fifo_level),
    .jdo            (jdo),
    .jir            (jir),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .overflow       (overflow),
    .ovf_clr        (ovf_clr),
    .cmd_count      (cmd_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    if (reset_n && (take_action != 4'b0 || take_no_action != 4'b0)) begin
      n_tests++;
      act = {jir, jdo, take_action, take_no_action};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pulse_unexpected: got jir=%0d jdo=%h ta=%b tna=%b, required no pulse",
                 jir, jdo, take_action, take_no_action);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL pulse_entry: got jir=%0d jdo=%h ta=%b tna=%b, required jir=%0d jdo=%h ta=%b tna=%b",
                   jir, jdo, take_action, take_no_action,
                   e[47:46], e[45:8], e[7:4], e[3:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic uir_strobe(input logic [1:0] v);
    ir_in  = v;
    vs_uir = 1'b1;
    step(4);
    vs_uir = 1'b0;
    step(4);
  endtask

  task automatic udr_strobe(input logic [37:0] d, input logic [1:0] ir,
                            input logic [3:0] ta, input logic [3:0] tna, input bit acc);
    sr     = d;
    vs_udr = 1'b1;
    if (acc) begin
      exp_q.push_back({ir, d, ta, tna});
      exp_cnt++;
    end
    step(4);
    vs_udr = 1'b0;
    step(4);
  endtask

  function automatic logic [15:0] exp_count();
`ifdef DEBUG_SLAVE_CMD_COUNT_EN
    return 16'(exp_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  // Stimulus
  initial begin
    n_tests   = 0;
    n_fail    = 0;
    exp_cnt   = 0;
    reset_n   = 1'b0;
    ir_in     = 2'b00;
    sr        = '0;
    vs_uir    = 1'b0;
    vs_udr    = 1'b1;
    cmd_ready = 1'b0;
    ovf_clr   = 1'b0;

    // Reset state, strobe held high across release
    step(3);
    @(negedge clk);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_pulses", 64'({take_action, take_no_action}), 64'd0);
    check("rst_jdo_jir", 64'({jir, jdo}), 64'd0);
    check("rst_cmd_count", 64'(cmd_count), 64'd0);
    step(1);
    reset_n = 1'b1;
    step(8);
    @(negedge clk);
    check("held_udr_no_push_valid", 64'(cmd_valid), 64'd0);
    check("held_udr_no_push_level", 64'(fifo_level), 64'd0);
    step(1);
    vs_udr = 1'b0;
    step(4);
    @(negedge clk);
    check("held_udr_fall_no_push", 64'(cmd_valid), 64'd0);

    // Single command, take_action, with push latency check
    cmd_ready = 1'b1;
    step(1);
    uir_strobe(2'b10);
    sr     = 38'h8_0000_1234;
    vs_udr = 1'b1;
    exp_q.push_back({2'd2, 38'h8_0000_1234, 4'b0100, 4'b0000});
    exp_cnt++;
    step(2);
    @(negedge clk);
    check("latency_valid_early", 64'(cmd_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("latency_valid_set", 64'(cmd_valid), 64'd1);
    check("latency_level_one", 64'(fifo_level), 64'd1);
    step(1);
    vs_udr = 1'b0;
    step(5);
    @(negedge clk);
    check("act_all_popped", 64'(exp_q.size()), 64'd0);
    check("act_jdo_held", 64'(jdo), 64'h8_0000_1234);
    check("act_jir_held", 64'(jir), 64'd2);
    check("act_valid_clear", 64'(cmd_valid), 64'd0);

    // take_no_action and other channels
    step(1);
    udr_strobe(38'h0_0000_5678, 2'd2, 4'b0000, 4'b0100, 1'b1);
    uir_strobe(2'b01);
    udr_strobe(38'h9_ABCD_0001, 2'd1, 4'b0010, 4'b0000, 1'b1);
    uir_strobe(2'b11);
    udr_strobe(38'h7_0000_0003, 2'd3, 4'b0000, 4'b1000, 1'b1);
    @(negedge clk);
    check("chan_all_popped", 64'(exp_q.size()), 64'd0);
    check("chan_jdo", 64'(jdo), 64'h7_0000_0003);
    check("chan_jir", 64'(jir), 64'd3);

    // Fill to overflow, then drain on consecutive cycles
    step(1);
    cmd_ready = 1'b0;
    uir_strobe(2'b00);
    udr_strobe(38'h8_0000_0001, 2'd0, 4'b0001, 4'b0000, 1'b1);
    udr_strobe(38'h0_0000_0002, 2'd0, 4'b0000, 4'b0001, 1'b1);
    udr_strobe(38'h8_0000_0003, 2'd0, 4'b0001, 4'b0000, 1'b1);
    udr_strobe(38'h0_0000_0004, 2'd0, 4'b0000, 4'b0001, 1'b1);
    @(negedge clk);
    check("full_level", 64'(fifo_level), 64'd4);
    check("full_no_overflow", 64'(overflow), 64'd0);
    step(1);
    udr_strobe(38'h8_0000_0005, 2'd0, 4'b0001, 4'b0000, 1'b0);
    @(negedge clk);
    check("drop_level", 64'(fifo_level), 64'd4);
    check("drop_overflow", 64'(overflow), 64'd1);
    check("drop_valid", 64'(cmd_valid), 64'd1);
    step(1);
    cmd_ready = 1'b1;
    step(3);
    @(negedge clk);
    check("drain_level_after3", 64'(fifo_level), 64'd1);
    step(1);
    @(negedge clk);
    check("drain_level_after4", 64'(fifo_level), 64'd0);
    step(2);
    @(negedge clk);
    check("drain_all_popped", 64'(exp_q.size()), 64'd0);
    check("overflow_sticky", 64'(overflow), 64'd1);
    step(1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_clr_alone", 64'(overflow), 64'd0);

    // Full queue: push coinciding with pop, then drop coinciding with clear
    step(1);
    cmd_ready = 1'b0;
    udr_strobe(38'h0_0000_0011, 2'd0, 4'b0000, 4'b0001, 1'b1);
    udr_strobe(38'h8_0000_0022, 2'd0, 4'b0001, 4'b0000, 1'b1);
    udr_strobe(38'h0_0000_0033, 2'd0, 4'b0000, 4'b0001, 1'b1);
    udr_strobe(38'h8_0000_0044, 2'd0, 4'b0001, 4'b0000, 1'b1);
    sr     = 38'h8_0000_0055;
    vs_udr = 1'b1;
    exp_q.push_back({2'd0, 38'h8_0000_0055, 4'b0001, 4'b0000});
    exp_cnt++;
    step(2);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    @(negedge clk);
    check("pushpop_level", 64'(fifo_level), 64'd4);
    check("pushpop_no_overflow", 64'(overflow), 64'd0);
    step(1);
    vs_udr = 1'b0;
    step(4);
    sr     = 38'h0_0000_0066;
    vs_udr = 1'b1;
    step(2);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    check("set_beats_clr", 64'(overflow), 64'd1);
    check("set_beats_clr_level", 64'(fifo_level), 64'd4);
    step(1);
    vs_udr = 1'b0;
    step(4);
    cmd_ready = 1'b1;
    step(6);
    @(negedge clk);
    check("pushpop_all_popped", 64'(exp_q.size()), 64'd0);
    check("pushpop_drained", 64'(fifo_level), 64'd0);
    step(4);
    @(negedge clk);
    check("ready_empty_jdo_held", 64'(jdo), 64'h8_0000_0055);
    check("ready_empty_jir_held", 64'(jir), 64'd0);

    // Push counter, then reset with entries queued
    step(1);
    cmd_ready = 1'b0;
    uir_strobe(2'b11);
    udr_strobe(38'h8_0000_0077, 2'd3, 4'b1000, 4'b0000, 1'b1);
    udr_strobe(38'h0_0000_0088, 2'd3, 4'b0000, 4'b1000, 1'b1);
    @(negedge clk);
    check("midrun_level", 64'(fifo_level), 64'd2);
    check("cmd_count_run", 64'(cmd_count), 64'(exp_count()));
    step(1);
    reset_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    step(2);
    @(negedge clk);
    check("midrst_valid", 64'(cmd_valid), 64'd0);
    check("midrst_level", 64'(fifo_level), 64'd0);
    check("midrst_cmd_count", 64'(cmd_count), 64'd0);
    step(1);
    reset_n = 1'b1;
    step(6);
    cmd_ready = 1'b1;
    udr_strobe(38'h8_0000_0042, 2'd0, 4'b0001, 4'b0000, 1'b1);
    step(2);
    @(negedge clk);
    check("postrst_all_popped", 64'(exp_q.size()), 64'd0);
    check("postrst_jir_cleared", 64'(jir), 64'd0);
    check("postrst_cmd_count", 64'(cmd_count), 64'(exp_count()));

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
